// File: rtl/sap1_hw_sequencer_if.sv
// Control bundle between the SAP-1 hardwired sequencer and its datapath.
// Step inputs exist only when SAP1_SINGLE_STEP_EN is defined.
interface sap1_hw_sequencer_if;
  logic       start;
  logic [3:0] ir_op;
`ifdef SAP1_SINGLE_STEP_EN
  logic       step_mode;
  logic       step;
`endif
  logic       ep, cp, sel, lm_n, ce_n, li_n, ei;
  logic       la_n, ea, sel_acc, lb_n, su, eu, lo_n;
  logic [3:0] state_o;
  logic       halted, illegal, instr_done;

  modport master (
`ifdef SAP1_SINGLE_STEP_EN
    input  step_mode, step,
`endif
    input  start, ir_op,
    output ep, cp, sel, lm_n, ce_n, li_n, ei,
    output la_n, ea, sel_acc, lb_n, su, eu, lo_n,
    output state_o, halted, illegal, instr_done
  );

  modport slave (
`ifdef SAP1_SINGLE_STEP_EN
    output step_mode, step,
`endif
    output start, ir_op,
    input  ep, cp, sel, lm_n, ce_n, li_n, ei,
    input  la_n, ea, sel_acc, lb_n, su, eu, lo_n,
    input  state_o, halted, illegal, instr_done
  );
endinterface

// File: rtl/sap1_hw_sequencer.sv
// Hardwired T-state sequencer for the SAP-1 datapath (registered Moore FSM).
// Optional single-step control is enabled with SAP1_SINGLE_STEP_EN.
module sap1_hw_sequencer #(
  parameter logic [3:0] LDA_OP     = 4'h0,
  parameter logic [3:0] ADD_OP     = 4'h1,
  parameter logic [3:0] OUT_OP     = 4'h2,
  parameter logic [3:0] SUB_OP     = 4'h3,
  parameter logic [3:0] HLT_OP     = 4'hF,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  sap1_hw_sequencer_if.master     bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_F3   = 4'd4,
    S_E0   = 4'd5,
    S_E1   = 4'd6,
    S_E2   = 4'd7,
    S_O0   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam state_t RESET_STATE = AUTO_START ? S_F0 : S_IDLE;

  state_t     state_reg, state_next;
  logic       hold_reg, hold_next;
  logic [3:0] op_reg, op_next;
  logic       step_mode_w, step_w;
  logic       mem_op, legal_op;

`ifdef SAP1_SINGLE_STEP_EN
  assign step_mode_w = bus.step_mode;
  assign step_w      = bus.step;
`else
  assign step_mode_w = 1'b0;
  assign step_w      = 1'b0;
`endif

  assign mem_op   = (bus.ir_op == LDA_OP) || (bus.ir_op == ADD_OP) || (bus.ir_op == SUB_OP);
  assign legal_op = mem_op || (bus.ir_op == OUT_OP) || (bus.ir_op == HLT_OP);

  // hold_reg marks an inert cycle: the one after reset, or F0 parked in step mode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= RESET_STATE;
      hold_reg  <= 1'b1;
      op_reg    <= 4'h0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      op_reg    <= op_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = 1'b0;
    op_next    = op_reg;
    if (hold_reg) begin
      hold_next = (state_reg == S_F0) && step_mode_w && !step_w;
    end else begin
      case (state_reg)
        S_IDLE: if (bus.start) state_next = S_F0;
        S_F0:   state_next = S_F1;
        S_F1:   state_next = S_F2;
        S_F2:   state_next = S_F3;
        S_F3: begin
          op_next = bus.ir_op;
          if (mem_op)                    state_next = S_E0;
          else if (bus.ir_op == OUT_OP)  state_next = S_O0;
          else if (bus.ir_op == HLT_OP)  state_next = S_HALT;
          else                           state_next = S_F0;
        end
        S_E0:   state_next = S_E1;
        S_E1:   state_next = (op_reg == LDA_OP) ? S_F0 : S_E2;
        S_E2:   state_next = S_F0;
        S_O0:   state_next = S_F0;
        S_HALT: state_next = S_HALT;
        default: state_next = S_F0;
      endcase
      hold_next = step_mode_w && (state_next == S_F0);
    end
  end

  always_comb begin
    bus.ep         = 1'b0;
    bus.cp         = 1'b0;
    bus.sel        = 1'b0;
    bus.lm_n       = 1'b1;
    bus.ce_n       = 1'b1;
    bus.li_n       = 1'b1;
    bus.ei         = 1'b0;
    bus.la_n       = 1'b1;
    bus.ea         = 1'b0;
    bus.sel_acc    = 1'b0;
    bus.lb_n       = 1'b1;
    bus.su         = 1'b0;
    bus.eu         = 1'b0;
    bus.lo_n       = 1'b1;
    bus.illegal    = 1'b0;
    bus.instr_done = 1'b0;
    bus.halted     = (state_reg == S_HALT);
    bus.state_o    = state_reg;
    if (!hold_reg) begin
      case (state_reg)
        S_F0: begin
          bus.ep   = 1'b1;
          bus.sel  = 1'b1;
          bus.lm_n = 1'b0;
        end
        S_F1: bus.cp = 1'b1;
        S_F2: begin
          bus.ce_n = 1'b0;
          bus.li_n = 1'b0;
        end
        S_F3: begin
          bus.illegal    = !legal_op;
          bus.instr_done = !legal_op;
        end
        S_E0: begin
          bus.ei   = 1'b1;
          bus.lm_n = 1'b0;
        end
        S_E1: begin
          bus.ce_n = 1'b0;
          if (op_reg == LDA_OP) begin
            bus.sel_acc    = 1'b1;
            bus.la_n       = 1'b0;
            bus.instr_done = 1'b1;
          end else begin
            bus.lb_n = 1'b0;
          end
        end
        S_E2: begin
          bus.eu         = 1'b1;
          bus.su         = (op_reg == SUB_OP);
          bus.la_n       = 1'b0;
          bus.instr_done = 1'b1;
        end
        S_O0: begin
          bus.ea         = 1'b1;
          bus.lo_n       = 1'b0;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_hw_sequencer.sv
// Bench for sap1_hw_sequencer: a small SAP-1 datapath model executes programs
// from the strobes; a second instance covers AUTO_START=0.
module tb_sap1_hw_sequencer;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_F0 = 4'd1, ST_F1 = 4'd2, ST_F2 = 4'd3,
                         ST_F3 = 4'd4, ST_E0 = 4'd5, ST_E1 = 4'd6, ST_E2 = 4'd7,
                         ST_O0 = 4'd8, ST_HALT = 4'd9;

  // {ep,cp,sel,lm_n,ce_n,li_n,ei,la_n,ea,sel_acc,lb_n,su,eu,lo_n}
  localparam logic [13:0] K_NONE  = 14'b000_1_1_1_0_1_0_0_1_0_0_1;
  localparam logic [13:0] K_F0    = 14'b101_0_1_1_0_1_0_0_1_0_0_1;
  localparam logic [13:0] K_F1    = 14'b010_1_1_1_0_1_0_0_1_0_0_1;
  localparam logic [13:0] K_F2    = 14'b000_1_0_0_0_1_0_0_1_0_0_1;
  localparam logic [13:0] K_E0    = 14'b000_0_1_1_1_1_0_0_1_0_0_1;
  localparam logic [13:0] K_E1LDA = 14'b000_1_0_1_0_0_0_1_1_0_0_1;
  localparam logic [13:0] K_E1ADD = 14'b000_1_0_1_0_1_0_0_0_0_0_1;
  localparam logic [13:0] K_E2ADD = 14'b000_1_1_1_0_0_0_0_1_0_1_1;
  localparam logic [13:0] K_O0    = 14'b000_1_1_1_0_1_1_0_1_0_0_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2;
  sap1_hw_sequencer_if sif ();
  sap1_hw_sequencer_if sif2 ();

  sap1_hw_sequencer #(.AUTO_START(1'b1)) dut  (.clk(clk), .rst(rst),  .bus(sif));
  sap1_hw_sequencer #(.AUTO_START(1'b0)) dut2 (.clk(clk), .rst(rst2), .bus(sif2));

  // datapath model
  logic [7:0] mem [16];
  logic [3:0] pc, mar;
  logic [7:0] ir, acc, breg, outr, dbus, alu;

  assign alu       = sif.su ? (acc - breg) : (acc + breg);
  assign sif.ir_op = ir[7:4];

  always_comb begin
    dbus = 8'h00;
    if (sif.ep)          dbus = {4'h0, pc};
    else if (!sif.ce_n)  dbus = mem[mar];
    else if (sif.ei)     dbus = {4'h0, ir[3:0]};
    else if (sif.ea)     dbus = acc;
    else if (sif.eu)     dbus = alu;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= 4'h0;
      ir <= 8'h00;
    end else begin
      if (!sif.lm_n) mar <= sif.sel ? pc : ir[3:0];
      if (sif.cp)    pc <= pc + 4'h1;
      if (!sif.li_n) ir <= dbus;
      if (!sif.la_n) acc <= sif.sel_acc ? dbus : alu;
      if (!sif.lb_n) breg <= dbus;
      if (!sif.lo_n) outr <= acc;
    end
  end

  logic [13:0] st1, st2;
  assign st1 = {sif.ep, sif.cp, sif.sel, sif.lm_n, sif.ce_n, sif.li_n, sif.ei,
                sif.la_n, sif.ea, sif.sel_acc, sif.lb_n, sif.su, sif.eu, sif.lo_n};
  assign st2 = {sif2.ep, sif2.cp, sif2.sel, sif2.lm_n, sif2.ce_n, sif2.li_n, sif2.ei,
                sif2.la_n, sif2.ea, sif2.sel_acc, sif2.lb_n, sif2.su, sif2.eu, sif2.lo_n};

  typedef struct {
    logic [3:0]  state;
    logic [13:0] strb;
    logic        done;
    logic        halt;
  } vec_t;

  vec_t vecs [30];
  int nv = 0;
  int errors = 0;
  int checks = 0;
  int done_cnt, su_cnt, su_bad, ill_cnt, low_cnt;
  logic found, ill_at_f3;

  task automatic add_vec(input logic [3:0] s, input logic [13:0] k, input logic d, input logic h);
    vecs[nv].state = s;
    vecs[nv].strb  = k;
    vecs[nv].done  = d;
    vecs[nv].halt  = h;
    nv++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("check %s ok (%0h)", name, act);
    end
  endtask

  task automatic add_fetch();
    add_vec(ST_F0, K_F0, 1'b0, 1'b0);
    add_vec(ST_F1, K_F1, 1'b0, 1'b0);
    add_vec(ST_F2, K_F2, 1'b0, 1'b0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    rst2 = 1'b0;
    sif.start = 1'b0;
    sif2.start = 1'b0;
    sif2.ir_op = 4'h0;
`ifdef SAP1_SINGLE_STEP_EN
    sif.step_mode = 1'b0;
    sif.step = 1'b0;
    sif2.step_mode = 1'b0;
    sif2.step = 1'b0;
`endif

    // program 1 trace: LDA 9, ADD A, ADD B, OUT, HLT
    add_fetch(); add_vec(ST_F3, K_NONE, 0, 0); add_vec(ST_E0, K_E0, 0, 0);
    add_vec(ST_E1, K_E1LDA, 1, 0);
    for (int n = 0; n < 2; n++) begin
      add_fetch(); add_vec(ST_F3, K_NONE, 0, 0); add_vec(ST_E0, K_E0, 0, 0);
      add_vec(ST_E1, K_E1ADD, 0, 0); add_vec(ST_E2, K_E2ADD, 1, 0);
    end
    add_fetch(); add_vec(ST_F3, K_NONE, 0, 0); add_vec(ST_O0, K_O0, 1, 0);
    add_fetch(); add_vec(ST_F3, K_NONE, 0, 0); add_vec(ST_HALT, K_NONE, 0, 1);

    clear_mem();
    mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'h1B; mem[3] = 8'h20; mem[4] = 8'hF0;
    mem[9] = 8'h01; mem[10] = 8'h02; mem[11] = 8'h03;

    repeat (3) @(negedge clk);
    check("rst_state", {28'h0, sif.state_o}, {28'h0, ST_F0});
    check("rst_strobes", {18'h0, st1}, {18'h0, K_NONE});
    check("rst_flags", {29'h0, sif.halted, sif.illegal, sif.instr_done}, 32'h0);

    rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      done_cnt += int'(sif.instr_done);
      check($sformatf("prog1_cyc%0d", i + 1),
            {12'h0, sif.state_o, st1, sif.instr_done, sif.halted},
            {12'h0, vecs[i].state, vecs[i].strb, vecs[i].done, vecs[i].halt});
    end
    check("prog1_out", {24'h0, outr}, 32'h06);
    check("prog1_done_cnt", done_cnt, 4);

    // SUB program: LDA B, SUB 9, OUT, HLT -> 3 - 1
    clear_mem();
    mem[0] = 8'h0B; mem[1] = 8'h39; mem[2] = 8'h20; mem[3] = 8'hF0;
    mem[9] = 8'h01; mem[11] = 8'h03;
    do_reset();
    su_cnt = 0; su_bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sif.su) begin
        su_cnt++;
        if (sif.state_o != ST_E2) su_bad++;
      end
      if (sif.halted) break;
    end
    check("sub_halted", {31'h0, sif.halted}, 32'h1);
    check("sub_out", {24'h0, outr}, 32'h02);
    check("sub_su_cnt", su_cnt, 1);
    check("sub_su_outside_e2", su_bad, 0);

    // illegal opcode 7 followed by HLT
    clear_mem();
    mem[0] = 8'h70; mem[1] = 8'hF0;
    do_reset();
    ill_cnt = 0; low_cnt = 0; ill_at_f3 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      ill_cnt += int'(sif.illegal);
      if (!sif.la_n || !sif.lb_n || !sif.lo_n) low_cnt++;
      if (c == 4 && sif.state_o == ST_F3 && sif.illegal && sif.instr_done) ill_at_f3 = 1'b1;
    end
    @(negedge clk);
    check("ill_next_f0", {28'h0, sif.state_o}, {28'h0, ST_F0});
    check("ill_pulse_cnt", ill_cnt, 1);
    check("ill_in_f3", {31'h0, ill_at_f3}, 32'h1);
    check("ill_no_loads", low_cnt, 0);

    // reset in E1 of ADD: LDA 9 then ADD A
    clear_mem();
    mem[0] = 8'h09; mem[1] = 8'h1A; mem[9] = 8'h01; mem[10] = 8'h02;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sif.state_o == ST_E1 && ir[7:4] == 4'h1) begin
        found = 1'b1;
        break;
      end
    end
    check("rstmid_reached_e1", {31'h0, found}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_strobes", {18'h0, st1}, {18'h0, K_NONE});
    check("rstmid_state", {28'h0, sif.state_o}, {28'h0, ST_F0});
    check("rstmid_acc", {24'h0, acc}, 32'h01);
    rst = 1'b1;

    // AUTO_START=0 instance
    rst2 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("idle_cyc%0d", c + 1), {14'h0, sif2.state_o, st2}, {14'h0, ST_IDLE, K_NONE});
    end
    sif2.start = 1'b1;
    @(negedge clk);
    sif2.start = 1'b0;
    check("idle_start_f0", {28'h0, sif2.state_o}, {28'h0, ST_F0});

`ifdef SAP1_SINGLE_STEP_EN
    clear_mem();
    mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'h1B; mem[3] = 8'h20; mem[4] = 8'hF0;
    mem[9] = 8'h01; mem[10] = 8'h02; mem[11] = 8'h03;
    sif.step_mode = 1'b1;
    do_reset();
    done_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      done_cnt += int'(sif.instr_done);
    end
    check("step_parked", {14'h0, sif.state_o, st1}, {14'h0, ST_F0, K_NONE});
    check("step_parked_done", done_cnt, 0);
    for (int s = 0; s < 3; s++) begin
      sif.step = 1'b1;
      @(negedge clk);
      sif.step = 1'b0;
      done_cnt = 0;
      repeat (15) begin
        @(negedge clk);
        done_cnt += int'(sif.instr_done);
      end
      check($sformatf("step%0d_done", s), done_cnt, 1);
      check($sformatf("step%0d_parked", s), {14'h0, sif.state_o, st1}, {14'h0, ST_F0, K_NONE});
    end
    sif.step_mode = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
